// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_pkg : shared types and constants for the MIPS fetch unit
// Revision 1.0
// ----------------------------------------------------------------------------
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      OUT   = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES   = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/mips_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_if : PC, instruction-memory, decode and redirect signals
// Revision 1.0
// ----------------------------------------------------------------------------
interface mips_fetch_if;

   logic [31:0] pc_in;
   logic [31:0] next_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   modport master (
      input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             id_ready, redirect_valid, redirect_target,
      output next_pc, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             id_ready, redirect_valid, redirect_target,
      input  next_pc, imem_req_valid, imem_addr, id_valid, id_instr, id_pc
   );

endinterface
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_next_pc : next-PC select (reset vector > redirect > pc+4 > hold)
// Revision 1.0
// ----------------------------------------------------------------------------
module fetch_next_pc
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  wire logic        reset_n_i,
   input  wire logic        redirect_valid_i,
   input  wire logic [31:0] redirect_target_i,
   input  wire logic        advance_i,
   input  wire logic [31:0] pc_in_i,
   output logic      [31:0] next_pc_o
);

   always_comb begin
      next_pc_o = pc_in_i;
      if (!reset_n_i) begin
         next_pc_o = RESET_VECTOR;
      end else if (redirect_valid_i) begin
         next_pc_o = redirect_target_i & PC_ALIGN_MASK;
      end else if (advance_i) begin
         next_pc_o = pc_in_i + INSTR_BYTES;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_unit : issue/wait/out fetch FSM with registered decode port
// Revision 1.0
// ----------------------------------------------------------------------------
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  wire logic   clock,
   input  wire logic   reset_n,
   mips_fetch_if.master fif
);

   fetch_state_e state_q, state_d;
   logic         kill_q, kill_d;
   logic         id_valid_q, id_valid_d;
   logic [31:0]  id_instr_q, id_instr_d;
   logic [31:0]  id_pc_q, id_pc_d;
   logic         req_valid;
   logic         advance;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= ISSUE;
         kill_q     <= 1'b0;
         id_valid_q <= 1'b0;
         id_instr_q <= 32'h0;
         id_pc_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      req_valid  = 1'b0;
      advance    = 1'b0;
      unique case (state_q)
         ISSUE: begin
            req_valid = !fif.redirect_valid;
            if (req_valid && fif.imem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            // A response racing a redirect, or marked stale, is dropped.
            if (fif.imem_rsp_valid) begin
               kill_d  = 1'b0;
               state_d = ISSUE;
               if (!fif.redirect_valid && !kill_q) begin
                  id_instr_d = fif.imem_rsp_data;
                  id_pc_d    = fif.pc_in;
                  id_valid_d = 1'b1;
                  state_d    = OUT;
               end
            end else if (fif.redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         OUT: begin
            if (fif.redirect_valid) begin
               id_valid_d = 1'b0;
               state_d    = ISSUE;
            end else if (id_valid_q && fif.id_ready) begin
               id_valid_d = 1'b0;
               advance    = 1'b1;
               state_d    = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase
   end

   fetch_next_pc #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_next_pc (
      .reset_n_i         (reset_n),
      .redirect_valid_i  (fif.redirect_valid),
      .redirect_target_i (fif.redirect_target),
      .advance_i         (advance),
      .pc_in_i           (fif.pc_in),
      .next_pc_o         (fif.next_pc)
   );

   assign fif.imem_req_valid = req_valid;
   assign fif.imem_addr      = fif.pc_in;
   assign fif.id_valid       = id_valid_q;
   assign fif.id_instr       = id_instr_q;
   assign fif.id_pc          = id_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_fetch_unit : directed vector table plus randomized model comparison
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mips_fetch_unit;

   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] D  = 32'h2008_0005;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] pc_reg = 32'h0;
   int          checks = 0;
   int          failures = 0;
   int          cur = 0;

   mips_fetch_if ifc();

   mips_fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .fif     (ifc)
   );

   always #5 clock = ~clock;
   always @(posedge clock) pc_reg <= ifc.next_pc;
   assign ifc.pc_in = pc_reg;

   typedef struct {
      bit          r, rr, rv;
      logic [31:0] dat;
      bit          ir, xv;
      logic [31:0] tg;
      logic [31:0] e_pc;
      bit          e_req;
      logic [31:0] e_next;
      bit          e_idv;
      logic [31:0] e_instr, e_idpc;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(bit r, bit rr, bit rv, logic [31:0] dat, bit ir, bit xv,
                               logic [31:0] tg, logic [31:0] e_pc, bit e_req,
                               logic [31:0] e_next, bit e_idv,
                               logic [31:0] e_instr, logic [31:0] e_idpc);
      vec_t v;
      v.r = r; v.rr = rr; v.rv = rv; v.dat = dat; v.ir = ir; v.xv = xv; v.tg = tg;
      v.e_pc = e_pc; v.e_req = e_req; v.e_next = e_next; v.e_idv = e_idv;
      v.e_instr = e_instr; v.e_idpc = e_idpc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h exp=%h", nm, cur, got, exp);
      end
   endtask

   task automatic drive(bit r, bit rr, bit rv, logic [31:0] dat, bit ir, bit xv, logic [31:0] tg);
      reset_n             = r;
      ifc.imem_req_ready  = rr;
      ifc.imem_rsp_valid  = rv;
      ifc.imem_rsp_data   = dat;
      ifc.id_ready        = ir;
      ifc.redirect_valid  = xv;
      ifc.redirect_target = tg;
   endtask

   // Transaction-level view: is a fetch in flight, is it stale, is an instruction held.
   bit          m_busy, m_stale, m_hold;
   logic [31:0] m_instr, m_pc;
   bit          mem_pend;

   initial begin
      tbl[0]  = mk(0,0,0,0,0,0,0,              RV,1,RV,                0,0,0);
      tbl[1]  = mk(1,1,0,0,0,0,0,              RV,1,RV,                0,0,0);
      tbl[2]  = mk(1,1,1,D,0,0,0,              RV,0,RV,                1,D,RV);
      for (int i = 3; i <= 7; i++)
         tbl[i] = mk(1,0,0,0,0,0,0,            RV,0,RV,                1,D,RV);
      tbl[8]  = mk(1,0,0,0,1,0,0,              RV,0,RV+4,              0,0,0);
      tbl[9]  = mk(1,1,0,0,0,0,0,              RV+4,1,RV+4,            0,0,0);
      tbl[10] = mk(1,0,0,0,0,1,32'h1003,       RV+4,0,32'h1000,        0,0,0);
      tbl[11] = mk(1,0,0,0,0,0,0,              32'h1000,0,32'h1000,    0,0,0);
      tbl[12] = mk(1,0,1,32'hDEAD_BEEF,0,0,0,  32'h1000,0,32'h1000,    0,0,0);
      tbl[13] = mk(1,1,0,0,0,0,0,              32'h1000,1,32'h1000,    0,0,0);
      tbl[14] = mk(1,0,1,D,0,1,32'h2002,       32'h1000,0,32'h2000,    0,0,0);
      tbl[15] = mk(1,1,0,0,0,0,0,              32'h2000,1,32'h2000,    0,0,0);
      tbl[16] = mk(1,0,1,32'h1234_5678,0,0,0,  32'h2000,0,32'h2000,    1,32'h1234_5678,32'h2000);
      tbl[17] = mk(1,0,0,0,1,1,32'h3001,       32'h2000,0,32'h3000,    0,0,0);
      tbl[18] = mk(1,1,0,0,0,1,32'hFFFF_FFFF,  32'h3000,0,32'hFFFF_FFFC,0,0,0);
      tbl[19] = mk(1,1,0,0,0,0,0,              32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,0,0);
      tbl[20] = mk(1,0,1,D,0,0,0,              32'hFFFF_FFFC,0,32'hFFFF_FFFC,1,D,32'hFFFF_FFFC);
      tbl[21] = mk(1,0,0,0,1,0,0,              32'hFFFF_FFFC,0,32'h0,  0,0,0);
      for (int i = 22; i <= 25; i++)
         tbl[i] = mk(1,0,0,0,0,0,0,            32'h0,1,32'h0,          0,0,0);
      tbl[26] = mk(1,1,0,0,0,0,0,              32'h0,1,32'h0,          0,0,0);
      tbl[27] = mk(0,0,0,0,0,0,0,              32'h0,0,RV,             0,0,0);
      tbl[28] = mk(1,0,0,0,0,0,0,              RV,1,RV,                0,0,0);

      drive(0,0,0,0,0,0,0);
      @(posedge clock); #1;

      for (int i = 0; i < 29; i++) begin
         cur = i;
         drive(tbl[i].r, tbl[i].rr, tbl[i].rv, tbl[i].dat, tbl[i].ir, tbl[i].xv, tbl[i].tg);
         #3;
         chk("tbl_imem_addr", ifc.imem_addr, tbl[i].e_pc);
         chk("tbl_req_valid", {31'b0, ifc.imem_req_valid}, {31'b0, tbl[i].e_req});
         chk("tbl_next_pc", ifc.next_pc, tbl[i].e_next);
         @(posedge clock); #1;
         chk("tbl_id_valid", {31'b0, ifc.id_valid}, {31'b0, tbl[i].e_idv});
         if (tbl[i].e_idv || !tbl[i].r) begin
            chk("tbl_id_instr", ifc.id_instr, tbl[i].e_instr);
            chk("tbl_id_pc", ifc.id_pc, tbl[i].e_idpc);
         end
      end

      m_busy = 0; m_stale = 0; m_hold = 0; m_instr = 0; m_pc = 0; mem_pend = 0;
      for (int c = 0; c < 1500; c++) begin
         bit          r, rr, rv, ir, xv, adv, hs, e_req;
         logic [31:0] dat, tg, e_next;
         cur = 1000 + c;
         r   = (c < 2) ? 1'b0 : (($urandom % 60) != 0);
         rr  = $urandom_range(0, 1);
         rv  = mem_pend && ($urandom_range(0, 2) != 0);
         dat = $urandom;
         ir  = $urandom_range(0, 1);
         xv  = ($urandom % 8) == 0;
         tg  = $urandom;
         drive(r, rr, rv, dat, ir, xv, tg);
         #3;
         adv    = m_hold && ir && !xv;
         e_req  = !m_busy && !m_hold && !xv;
         e_next = !r ? RV : xv ? {tg[31:2], 2'b00} : adv ? pc_reg + 32'd4 : pc_reg;
         chk("rnd_imem_addr", ifc.imem_addr, pc_reg);
         chk("rnd_req_valid", {31'b0, ifc.imem_req_valid}, {31'b0, e_req});
         chk("rnd_next_pc", ifc.next_pc, e_next);
         hs = ifc.imem_req_valid && rr;
         if (!r) begin
            m_busy = 0; m_stale = 0; m_hold = 0;
         end else if (m_hold) begin
            if (xv || ir) m_hold = 0;
         end else if (m_busy) begin
            if (rv) begin
               m_busy = 0;
               if (!xv && !m_stale) begin
                  m_hold = 1; m_instr = dat; m_pc = pc_reg;
               end
               m_stale = 0;
            end else if (xv) begin
               m_stale = 1;
            end
         end else if (e_req && rr) begin
            m_busy = 1;
         end
         @(posedge clock); #1;
         if (!r) mem_pend = 0;
         else begin
            if (rv) mem_pend = 0;
            if (hs) mem_pend = 1;
         end
         chk("rnd_id_valid", {31'b0, ifc.id_valid}, {31'b0, m_hold});
         if (m_hold) begin
            chk("rnd_id_instr", ifc.id_instr, m_instr);
            chk("rnd_id_pc", ifc.id_pc, m_pc);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch controller for the MIPS processor, sitting between the PC register and the IF/ID stage. It reads the current PC value and fetches the instruction at that address from instruction memory using a valid/ready request/response protocol. It delivers the instruction and its PC downstream through a registered valid/ready port, and it drives the PC register's next-value input every cycle. It is the PC's consumer and producer: the PC register loads `next_pc` unconditionally on every clock edge, so this block must re-drive the held value whenever the PC is not advancing.

## Interface
Parameters:
- `RESET_VECTOR`, `32'h0000_0000`, PC value driven during reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `pc_in`  in  32  current PC, taken from the PC register output.
- `next_pc`  out  32  value the PC register loads at the next edge.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  instruction memory accepts the request.
- `imem_addr`  out  32  fetch address; always equals `pc_in`.
- `imem_rsp_valid`  in  1  response data valid; exactly one response per accepted request, in order.
- `imem_rsp_data`  in  32  instruction word.
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode accepts the instruction.
- `id_instr`  out  32  registered instruction.
- `id_pc`  out  32  registered PC of `id_instr`.
- `redirect_valid`  in  1  branch/jump taken; flushes fetch.
- `redirect_target`  in  32  new PC; bits [1:0] are ignored and forced to 0.

## Operation
- FSM states:
  - `ISSUE`: request pending.
  - `WAIT`: request accepted, response outstanding.
  - `OUT`: instruction held for decode.
- Kill flag: 1 bit, marks the outstanding response as stale.
- Reset (`reset_n`=0 at an edge):
  - state←`ISSUE`, kill←0, `id_valid`←0, `id_instr`←0, `id_pc`←0.
  - `next_pc`=`RESET_VECTOR` combinationally while `reset_n`=0; `redirect_valid` is ignored.
- `ISSUE`:
  - `imem_req_valid` = !`redirect_valid`.
  - On `imem_req_valid`&&`imem_req_ready` → `WAIT`.
- `WAIT`:
  - On `imem_rsp_valid` with kill=0: `id_instr`←data, `id_pc`←`pc_in`, `id_valid`←1 → `OUT`.
  - On `imem_rsp_valid` with kill=1: discard the data, kill←0 → `ISSUE`.
- `OUT`: on `id_valid`&&`id_ready`, `id_valid`←0 → `ISSUE`; `next_pc`=`pc_in`+4 in that cycle.
- `next_pc` in all other cases = `pc_in` (hold).
- Redirect has the highest priority, regardless of state:
  - `next_pc`={target[31:2],2'b00}.
  - `ISSUE`: no request is issued that cycle; stay `ISSUE`.
  - `WAIT` without a response this cycle: kill←1, stay `WAIT`.
  - `WAIT` with a response in the same cycle: discard the response → `ISSUE`.
  - `OUT`: `id_valid`←0 (decode handshake suppressed, no +4) → `ISSUE`.
- Arithmetic: `pc_in`+4 is modulo 2^32; `32'hFFFF_FFFC` wraps to 0.

## Timing
- Minimum latency from request handshake in cycle N:
  - response in N+1;
  - `id_valid`=1 from N+2;
  - decode accepts in N+2;
  - next request in N+3.
- Peak throughput: one instruction per 3 cycles.
- `id_valid`, `id_instr` and `id_pc` are registered outputs.
- `imem_req_valid` and `next_pc` are combinational from state, `pc_in` and the redirect inputs.
- `id_instr` and `id_pc` are stable while `id_valid`=1 and `id_ready`=0.
- `imem_addr` is stable from request assertion until the handshake, because the PC holds.
- Reset mid-`WAIT`: the late response is dropped. The post-reset state is `ISSUE` with no outstanding request, and the memory side must also be reset.

## Structure
- Package `mips_fetch_pkg`:
  - state encoding (`ISSUE`, `WAIT`, `OUT`);
  - `INSTR_BYTES`=4;
  - `PC_ALIGN_MASK`=`32'hFFFF_FFFC`.
- One natural sub-module: `fetch_next_pc`, the combinational mux selecting reset vector, aligned redirect, `pc_in`+4 or `pc_in`, in that priority order.
- The FSM and output registers live in `mips_fetch_unit`.

## Test plan
- Reset with `RESET_VECTOR`=`32'h0040_0000`, memory always ready with 1-cycle response returning `32'h2008_0005` → first `id_valid` at cycle 3 after reset release, with `id_pc`=`32'h0040_0000`; next `imem_addr`=`32'h0040_0004`.
- Hold `id_ready`=0 for 5 cycles while in `OUT` → `id_instr`/`id_pc` stable, `next_pc`=`pc_in`, no new request; on `id_ready`=1 → `next_pc`=`pc_in`+4.
- Redirect to `32'h0000_1003` during `WAIT`, response arrives 2 cycles later → response discarded, `id_valid` stays 0, next `imem_addr`=`32'h0000_1000`.
- Redirect in the same cycle as `imem_rsp_valid` in `WAIT`, and separately in the same cycle as `id_ready` in `OUT` → no instruction delivered, no +4, `next_pc`=aligned target.
- `pc_in`=`32'hFFFF_FFFC` accepted by decode → `next_pc`=`32'h0000_0000`.
- Memory `imem_req_ready` low for 4 cycles, then `reset_n`=0 during `WAIT` → `imem_addr` stable while stalled; after reset, `id_valid`=0, `next_pc`=`RESET_VECTOR`, state `ISSUE`.
